// File: rtl/trace_packet_decoder_if.sv
// +----------------------------------------------------------------------------+
// | trace_packet_decoder_if : packet-in / event-out stream bundle               |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface trace_packet_decoder_if #(
  parameter int TIME_W = 48,
  parameter int BEAT_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_type;
  logic [22:0]       in_payload;
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_write;
  logic [22:0]       ev_addr;
  logic [15:0]       ev_data;
  logic [1:0]        ev_ublb;
  logic [TIME_W-1:0] ev_time;
  logic [BEAT_W-1:0] ev_beat;

  modport master (
    output in_valid, in_type, in_payload, ev_ready,
    input  in_ready, ev_valid, ev_write, ev_addr, ev_data, ev_ublb, ev_time, ev_beat
  );

  modport slave (
    input  in_valid, in_type, in_payload, ev_ready,
    output in_ready, ev_valid, ev_write, ev_addr, ev_data, ev_ublb, ev_time, ev_beat
  );
endinterface

`default_nettype wire

// File: rtl/trace_packet_decoder.sv
// +----------------------------------------------------------------------------+
// | trace_packet_decoder : rebuilds absolute-time RAM access events from the   |
// | tracer's address / read / write / timestamp packet stream. Rev 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module trace_packet_decoder #(
  parameter int TIME_W = 48,
  parameter int BEAT_W = 8
) (
  input  logic                   mclk,
  input  logic                   reset,
  trace_packet_decoder_if.slave  bus,
  output logic                   err_orphan
);

  localparam logic [1:0] PKT_ADDR  = 2'b00;
  localparam logic [1:0] PKT_READ  = 2'b01;
  localparam logic [1:0] PKT_WRITE = 2'b10;
  localparam logic [1:0] PKT_TS    = 2'b11;

  logic [TIME_W-1:0] time_q, time_d;
  logic [22:0]       cur_addr_q, cur_addr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              addr_seen_q, addr_seen_d;
  logic              ev_valid_q, ev_valid_d;
  logic              ev_write_q, ev_write_d;
  logic [22:0]       ev_addr_q, ev_addr_d;
  logic [15:0]       ev_data_q, ev_data_d;
  logic [1:0]        ev_ublb_q, ev_ublb_d;
  logic [TIME_W-1:0] ev_time_q, ev_time_d;
  logic [BEAT_W-1:0] ev_beat_q, ev_beat_d;
  logic              err_orphan_q, err_orphan_d;

  logic              in_ready_w;
  logic              accept_w;
  logic [TIME_W-1:0] t_word_w;

  // Backpressure applies to every packet type so the stream stays ordered.
  assign in_ready_w = !ev_valid_q || bus.ev_ready;
  assign accept_w   = bus.in_valid && in_ready_w;
  assign t_word_w   = time_q + TIME_W'(bus.in_payload[22:18]);

  always_comb begin
    time_d       = time_q;
    cur_addr_d   = cur_addr_q;
    beat_d       = beat_q;
    addr_seen_d  = addr_seen_q;
    ev_valid_d   = ev_valid_q;
    ev_write_d   = ev_write_q;
    ev_addr_d    = ev_addr_q;
    ev_data_d    = ev_data_q;
    ev_ublb_d    = ev_ublb_q;
    ev_time_d    = ev_time_q;
    ev_beat_d    = ev_beat_q;
    err_orphan_d = err_orphan_q;

    if (ev_valid_q && bus.ev_ready) begin
      ev_valid_d = 1'b0;
    end

    if (accept_w) begin
      case (bus.in_type)
        PKT_ADDR: begin
          cur_addr_d  = bus.in_payload;
          beat_d      = '0;
          addr_seen_d = 1'b1;
        end
        PKT_TS: begin
          time_d = time_q + TIME_W'(bus.in_payload);
        end
        PKT_READ, PKT_WRITE: begin
          time_d = t_word_w;
          if (addr_seen_q) begin
            ev_valid_d = 1'b1;
            ev_write_d = bus.in_type[1];
            ev_addr_d  = cur_addr_q + 23'(beat_q);
            ev_data_d  = bus.in_payload[15:0];
            ev_ublb_d  = bus.in_payload[17:16];
            ev_time_d  = t_word_w;
            ev_beat_d  = beat_q;
            if (beat_q != '1) begin
              beat_d = beat_q + 1'b1;
            end
          end else begin
            err_orphan_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      time_q       <= '0;
      cur_addr_q   <= '0;
      beat_q       <= '0;
      addr_seen_q  <= 1'b0;
      ev_valid_q   <= 1'b0;
      ev_write_q   <= 1'b0;
      ev_addr_q    <= '0;
      ev_data_q    <= '0;
      ev_ublb_q    <= '0;
      ev_time_q    <= '0;
      ev_beat_q    <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      time_q       <= time_d;
      cur_addr_q   <= cur_addr_d;
      beat_q       <= beat_d;
      addr_seen_q  <= addr_seen_d;
      ev_valid_q   <= ev_valid_d;
      ev_write_q   <= ev_write_d;
      ev_addr_q    <= ev_addr_d;
      ev_data_q    <= ev_data_d;
      ev_ublb_q    <= ev_ublb_d;
      ev_time_q    <= ev_time_d;
      ev_beat_q    <= ev_beat_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign bus.in_ready = in_ready_w;
  assign bus.ev_valid = ev_valid_q;
  assign bus.ev_write = ev_write_q;
  assign bus.ev_addr  = ev_addr_q;
  assign bus.ev_data  = ev_data_q;
  assign bus.ev_ublb  = ev_ublb_q;
  assign bus.ev_time  = ev_time_q;
  assign bus.ev_beat  = ev_beat_q;
  assign err_orphan   = err_orphan_q;

endmodule

`default_nettype wire

// File: tb/tb_trace_packet_decoder.sv
// +----------------------------------------------------------------------------+
// | tb_trace_packet_decoder : directed vectors against an 8-bit-time build and  |
// | a default 48-bit-time build fed the same stream. Rev 1.0                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_trace_packet_decoder;

  logic mclk  = 1'b0;
  logic reset = 1'b1;
  logic err8, err48;
  int   checks = 0;
  int   errors = 0;

  always #5 mclk = ~mclk;

  trace_packet_decoder_if #(.TIME_W(8),  .BEAT_W(8)) u_if8 ();
  trace_packet_decoder_if #(.TIME_W(48), .BEAT_W(8)) u_if48 ();

  assign u_if48.in_valid   = u_if8.in_valid;
  assign u_if48.in_type    = u_if8.in_type;
  assign u_if48.in_payload = u_if8.in_payload;
  assign u_if48.ev_ready   = u_if8.ev_ready;

  trace_packet_decoder #(.TIME_W(8), .BEAT_W(8)) u_dut8 (
    .mclk       (mclk),
    .reset      (reset),
    .bus        (u_if8.slave),
    .err_orphan (err8)
  );

  trace_packet_decoder #(.TIME_W(48), .BEAT_W(8)) u_dut48 (
    .mclk       (mclk),
    .reset      (reset),
    .bus        (u_if48.slave),
    .err_orphan (err48)
  );

  typedef struct {
    logic [1:0]  typ;
    logic [22:0] pl;
    logic        ev;
    logic        wr;
    logic [22:0] addr;
    logic [15:0] data;
    logic [1:0]  ublb;
    logic [7:0]  t8;
    logic [47:0] t48;
    logic [7:0]  beat;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [22:0] wp(input logic [4:0] ts, input logic [1:0] ub, input logic [15:0] d);
    return {ts, ub, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input logic wr, input logic [22:0] addr,
                        input logic [15:0] data, input logic [1:0] ublb,
                        input logic [7:0] t8, input logic [47:0] t48, input logic [7:0] beat);
    chk({tag, ".valid"},   64'(u_if8.ev_valid),  64'd1);
    chk({tag, ".valid48"}, 64'(u_if48.ev_valid), 64'd1);
    chk({tag, ".write"},   64'(u_if8.ev_write),  64'(wr));
    chk({tag, ".addr"},    64'(u_if8.ev_addr),   64'(addr));
    chk({tag, ".addr48"},  64'(u_if48.ev_addr),  64'(addr));
    chk({tag, ".data"},    64'(u_if8.ev_data),   64'(data));
    chk({tag, ".ublb"},    64'(u_if8.ev_ublb),   64'(ublb));
    chk({tag, ".time8"},   64'(u_if8.ev_time),   64'(t8));
    chk({tag, ".time48"},  64'(u_if48.ev_time),  64'(t48));
    chk({tag, ".beat"},    64'(u_if8.ev_beat),   64'(beat));
  endtask

  task automatic chk_noev(input string tag);
    chk({tag, ".valid"},   64'(u_if8.ev_valid),  64'd0);
    chk({tag, ".valid48"}, 64'(u_if48.ev_valid), 64'd0);
  endtask

  // Present one packet for exactly one edge; inputs change 1 time unit after the edge.
  task automatic apply(input logic [1:0] typ, input logic [22:0] pl);
    u_if8.in_type    = typ;
    u_if8.in_payload = pl;
    u_if8.in_valid   = 1'b1;
    @(posedge mclk);
    #1;
    u_if8.in_valid   = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge mclk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".valid"},   64'(u_if8.ev_valid),  64'd0);
    chk({tag, ".valid48"}, 64'(u_if48.ev_valid), 64'd0);
    chk({tag, ".write"},   64'(u_if8.ev_write),  64'd0);
    chk({tag, ".addr"},    64'(u_if8.ev_addr),   64'd0);
    chk({tag, ".data"},    64'(u_if8.ev_data),   64'd0);
    chk({tag, ".ublb"},    64'(u_if8.ev_ublb),   64'd0);
    chk({tag, ".time8"},   64'(u_if8.ev_time),   64'd0);
    chk({tag, ".time48"},  64'(u_if48.ev_time),  64'd0);
    chk({tag, ".beat"},    64'(u_if8.ev_beat),   64'd0);
    chk({tag, ".err"},     64'(err8),            64'd0);
    chk({tag, ".err48"},   64'(err48),           64'd0);
  endtask

  initial begin
    vecs[0]  = '{2'd0, 23'h000100,             1'b0, 1'b0, 23'h0,      16'h0,    2'd0, 8'h00, 48'h0,      8'd0};
    vecs[1]  = '{2'd2, wp(5'd3, 2'd0, 16'hBEEF), 1'b1, 1'b1, 23'h000100, 16'hBEEF, 2'd0, 8'h03, 48'h3,      8'd0};
    vecs[2]  = '{2'd2, wp(5'd1, 2'd0, 16'h1234), 1'b1, 1'b1, 23'h000101, 16'h1234, 2'd0, 8'h04, 48'h4,      8'd1};
    vecs[3]  = '{2'd3, 23'h000050,             1'b0, 1'b0, 23'h0,      16'h0,    2'd0, 8'h00, 48'h0,      8'd0};
    vecs[4]  = '{2'd0, 23'h7FFFFF,             1'b0, 1'b0, 23'h0,      16'h0,    2'd0, 8'h00, 48'h0,      8'd0};
    vecs[5]  = '{2'd1, wp(5'd0, 2'd3, 16'hA5A5), 1'b1, 1'b0, 23'h7FFFFF, 16'hA5A5, 2'd3, 8'h54, 48'h54,     8'd0};
    vecs[6]  = '{2'd1, wp(5'd0, 2'd2, 16'h0001), 1'b1, 1'b0, 23'h000000, 16'h0001, 2'd2, 8'h54, 48'h54,     8'd1};
    vecs[7]  = '{2'd1, wp(5'd31, 2'd1, 16'h7777), 1'b1, 1'b0, 23'h000001, 16'h7777, 2'd1, 8'h73, 48'h73,    8'd2};
    vecs[8]  = '{2'd3, 23'h7FFFFF,             1'b0, 1'b0, 23'h0,      16'h0,    2'd0, 8'h00, 48'h0,      8'd0};
    vecs[9]  = '{2'd1, wp(5'd0, 2'd0, 16'h0000), 1'b1, 1'b0, 23'h000002, 16'h0000, 2'd0, 8'h72, 48'h800072, 8'd3};
    vecs[10] = '{2'd3, 23'd200,                1'b0, 1'b0, 23'h0,      16'h0,    2'd0, 8'h00, 48'h0,      8'd0};
    vecs[11] = '{2'd3, 23'd100,                1'b0, 1'b0, 23'h0,      16'h0,    2'd0, 8'h00, 48'h0,      8'd0};
    vecs[12] = '{2'd2, wp(5'd2, 2'd1, 16'hCAFE), 1'b1, 1'b1, 23'h000003, 16'hCAFE, 2'd1, 8'hA0, 48'h8001A0, 8'd4};

    u_if8.in_valid   = 1'b0;
    u_if8.in_type    = 2'd0;
    u_if8.in_payload = '0;
    u_if8.ev_ready   = 1'b1;
    repeat (2) @(posedge mclk);
    #1;
    reset = 1'b0;
    chk_reset_outputs("reset");
    chk("reset.in_ready", 64'(u_if8.in_ready), 64'd1);

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].typ, vecs[i].pl);
      if (vecs[i].ev)
        chk_ev($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
               vecs[i].ublb, vecs[i].t8, vecs[i].t48, vecs[i].beat);
      else
        chk_noev($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.err", i), 64'(err8), 64'd0);
    end

    // Data word before any address: no event, sticky error, time still advances.
    pulse_reset();
    apply(2'd1, wp(5'd5, 2'd0, 16'h1111));
    chk_noev("orphan");
    chk("orphan.err",   64'(err8),  64'd1);
    chk("orphan.err48", 64'(err48), 64'd1);
    apply(2'd0, 23'h000010);
    chk("orphan.err_sticky", 64'(err8), 64'd1);
    apply(2'd1, wp(5'd2, 2'd0, 16'h2222));
    chk_ev("orphan_ev", 1'b0, 23'h000010, 16'h2222, 2'd0, 8'h07, 48'h7, 8'd0);
    chk("orphan.err_after", 64'(err8), 64'd1);

    // Stall: event held, further packets blocked, then drained one per cycle.
    apply(2'd0, 23'h000020);
    u_if8.ev_ready = 1'b0;
    apply(2'd1, wp(5'd1, 2'd0, 16'h0A01));
    chk_ev("stall1", 1'b0, 23'h000020, 16'h0A01, 2'd0, 8'h08, 48'h8, 8'd0);
    u_if8.in_type    = 2'd1;
    u_if8.in_payload = wp(5'd1, 2'd0, 16'h0A02);
    u_if8.in_valid   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall.in_ready%0d", c), 64'(u_if8.in_ready), 64'd0);
      chk($sformatf("stall.valid%0d", c),    64'(u_if8.ev_valid), 64'd1);
      chk($sformatf("stall.data%0d", c),     64'(u_if8.ev_data),  64'h0A01);
      chk($sformatf("stall.time%0d", c),     64'(u_if8.ev_time),  64'h08);
      @(posedge mclk);
      #1;
    end
    u_if8.ev_ready = 1'b1;
    #1;
    chk("release.in_ready", 64'(u_if8.in_ready), 64'd1);
    @(posedge mclk);
    #1;
    chk_ev("stall2", 1'b0, 23'h000021, 16'h0A02, 2'd0, 8'h09, 48'h9, 8'd1);
    u_if8.in_payload = wp(5'd1, 2'd0, 16'h0A03);
    @(posedge mclk);
    #1;
    chk_ev("stall3", 1'b0, 23'h000022, 16'h0A03, 2'd0, 8'h0A, 48'hA, 8'd2);
    u_if8.in_valid = 1'b0;
    @(posedge mclk);
    #1;
    chk_noev("drained");

    // Long burst: beat saturates at 255 and the address stops advancing.
    pulse_reset();
    apply(2'd0, 23'h000000);
    for (int i = 0; i < 300; i++) begin
      apply(2'd2, wp(5'd0, 2'd0, 16'(i)));
      chk($sformatf("burst%0d.valid", i), 64'(u_if8.ev_valid), 64'd1);
      chk($sformatf("burst%0d.addr", i),  64'(u_if8.ev_addr),  64'((i < 255) ? i : 255));
      chk($sformatf("burst%0d.beat", i),  64'(u_if8.ev_beat),  64'((i < 255) ? i : 255));
    end
    chk("burst.data",   64'(u_if8.ev_data), 64'(299));
    chk("burst.time48", 64'(u_if48.ev_time), 64'd0);

    // Reset while an event is held clears it without waiting for a clock edge.
    chk("pre_reset.valid", 64'(u_if8.ev_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    @(posedge mclk);
    #1;
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
